// File: rtl/pos_txn_ctrl.sv
// POS sale controller: switch sync/debounce, sale FSM, item/total bookkeeping
// and a sequential binary-to-BCD converter for the total readout.
module pos_txn_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned MAX_ITEMS       = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  sw,
  output logic [1:0]  state,
  output logic [3:0]  item_count,
  output logic [3:0]  last_item,
  output logic [13:0] total_cents,
  output logic [15:0] total_bcd,
  output logic        bcd_valid,
  output logic        err
);

  localparam int unsigned CntW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [3:0]  MaxCnt = 4'(MAX_ITEMS);

  typedef enum logic [1:0] {StIdle = 2'd0, StScan = 2'd1, StDone = 2'd2} state_e;

  state_e      state_q, state_d;
  logic [7:0]  sync1_q, sync2_q;
  logic [3:0]  db_q, rise_q;
  logic [CntW-1:0] db_cnt_q [4];
  logic [3:0]  count_q, count_d, last_q, last_d;
  logic        lv_q, lv_d, err_q, err_d;
  logic [13:0] total_q, total_d;
  logic        do_clear, do_start, do_acc, do_void;
  logic [9:0]  price_new, price_last;
  logic [14:0] sum;

  // 50*(c+1) = 32p + 16p + 2p with p = c+1
  function automatic logic [9:0] price(input logic [3:0] c);
    logic [4:0] p;
    p = {1'b0, c} + 5'd1;
    return {p, 5'b0} + {1'b0, p, 4'b0} + {4'b0, p, 1'b0};
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      db_q    <= '0;
      rise_q  <= '0;
      for (int i = 0; i < 4; i++) db_cnt_q[i] <= '0;
    end else begin
      sync1_q <= sw;
      sync2_q <= sync1_q;
      for (int i = 0; i < 4; i++) begin
        rise_q[i] <= 1'b0;
        if (sync2_q[4+i] != db_q[i]) begin
          if (db_cnt_q[i] == CntW'(DEBOUNCE_CYCLES - 1)) begin
            db_q[i]     <= sync2_q[4+i];
            db_cnt_q[i] <= '0;
            rise_q[i]   <= sync2_q[4+i];
          end else begin
            db_cnt_q[i] <= db_cnt_q[i] + 1'b1;
          end
        end else begin
          db_cnt_q[i] <= '0;
        end
      end
    end
  end

  assign price_new  = price(sync2_q[3:0]);
  assign price_last = price(last_q);
  assign sum        = {1'b0, total_q} + {5'b0, price_new};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // rise_q = {pay, cancel, void, add}; priority cancel > pay > void > add
  always_comb begin
    state_d  = state_q;
    err_d    = 1'b0;
    do_clear = 1'b0;
    do_start = 1'b0;
    do_acc   = 1'b0;
    do_void  = 1'b0;
    if (rise_q[2]) begin
      do_clear = 1'b1;
      state_d  = StIdle;
    end else if (rise_q[3]) begin
      case (state_q)
        StIdle:  err_d = 1'b1;
        StScan:  state_d = StDone;
        default: ;
      endcase
    end else if (rise_q[1]) begin
      if (state_q == StScan && lv_q) begin
        do_void = 1'b1;
        if (count_q == 4'd1) state_d = StIdle;
      end else begin
        err_d = 1'b1;
      end
    end else if (rise_q[0]) begin
      case (state_q)
        StIdle: begin
          do_start = 1'b1;
          state_d  = StScan;
        end
        StScan: begin
          if (count_q < MaxCnt && sum <= 15'd9999) do_acc = 1'b1;
          else err_d = 1'b1;
        end
        default: err_d = 1'b1;
      endcase
    end
  end

  always_comb begin
    count_d = count_q;
    last_d  = last_q;
    lv_d    = lv_q;
    total_d = total_q;
    if (do_clear) begin
      count_d = '0;
      last_d  = '0;
      lv_d    = 1'b0;
      total_d = '0;
    end else if (do_start) begin
      count_d = 4'd1;
      last_d  = sync2_q[3:0];
      lv_d    = 1'b1;
      total_d = {4'b0, price_new};
    end else if (do_acc) begin
      count_d = count_q + 4'd1;
      last_d  = sync2_q[3:0];
      lv_d    = 1'b1;
      total_d = sum[13:0];
    end else if (do_void) begin
      count_d = count_q - 4'd1;
      lv_d    = 1'b0;
      total_d = total_q - {4'b0, price_last};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      last_q  <= '0;
      lv_q    <= 1'b0;
      total_q <= '0;
      err_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      last_q  <= last_d;
      lv_q    <= lv_d;
      total_q <= total_d;
      err_q   <= err_d;
    end
  end

  // Double-dabble: shift register {bcd[15:0], bin[13:0]}, one iteration per cycle
  logic        bcd_busy_q, bcd_valid_q;
  logic [3:0]  bcd_cnt_q;
  logic [29:0] bcd_sh_q;
  logic [13:0] bcd_src_q;
  logic [15:0] bcd_q;

  function automatic logic [29:0] dd_step(input logic [29:0] s);
    logic [29:0] t;
    t = s;
    for (int d = 0; d < 4; d++) begin
      if (t[14+4*d +: 4] >= 4'd5) t[14+4*d +: 4] = t[14+4*d +: 4] + 4'd3;
    end
    return {t[28:0], 1'b0};
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcd_busy_q  <= 1'b0;
      bcd_valid_q <= 1'b1;
      bcd_cnt_q   <= '0;
      bcd_sh_q    <= '0;
      bcd_src_q   <= '0;
      bcd_q       <= '0;
    end else if (total_q != bcd_src_q) begin
      bcd_busy_q  <= 1'b1;
      bcd_valid_q <= 1'b0;
      bcd_cnt_q   <= '0;
      bcd_sh_q    <= {16'b0, total_q};
      bcd_src_q   <= total_q;
    end else if (bcd_busy_q) begin
      if (bcd_cnt_q == 4'd14) begin
        bcd_q       <= bcd_sh_q[29:14];
        bcd_valid_q <= 1'b1;
        bcd_busy_q  <= 1'b0;
      end else begin
        bcd_sh_q  <= dd_step(bcd_sh_q);
        bcd_cnt_q <= bcd_cnt_q + 4'd1;
      end
    end
  end

  assign state       = state_q;
  assign item_count  = count_q;
  assign last_item   = last_q;
  assign total_cents = total_q;
  assign total_bcd   = bcd_q;
  assign bcd_valid   = bcd_valid_q;
  assign err         = err_q;

endmodule

// File: tb/tb_pos_txn_ctrl.sv
// Bench for pos_txn_ctrl: directed scenarios plus random event sequences
// compared against a plain-arithmetic sale model.
module tb_pos_txn_ctrl;
  localparam int unsigned DB   = 4;
  localparam int unsigned MAXI = 15;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  sw;
  logic [1:0]  state;
  logic [3:0]  item_count, last_item;
  logic [13:0] total_cents;
  logic [15:0] total_bcd;
  logic        bcd_valid, err;

  pos_txn_ctrl #(.DEBOUNCE_CYCLES(DB), .MAX_ITEMS(MAXI)) dut (
    .clk(clk), .rst_n(rst_n), .sw(sw), .state(state), .item_count(item_count),
    .last_item(last_item), .total_cents(total_cents), .total_bcd(total_bcd),
    .bcd_valid(bcd_valid), .err(err)
  );

  always #5 clk = ~clk;

  int total_n = 0;
  int bad_n   = 0;
  int err_seen = 0;

  always @(negedge clk) if (rst_n && err) err_seen++;

  task automatic check_eq(input string tag, input int got, input int exp);
    total_n++;
    if (got != exp) begin
      bad_n++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Sale model: 0 idle, 1 scanning, 2 paid
  int m_state, m_count, m_last, m_total;
  bit m_lv;

  function automatic int price(input int c);
    return 50 * (c + 1);
  endfunction

  function automatic int to_bcd(input int t);
    return ((t / 1000) % 10) * 4096 + ((t / 100) % 10) * 256 + ((t / 10) % 10) * 16 + t % 10;
  endfunction

  task automatic model_clear();
    m_state = 0; m_count = 0; m_last = 0; m_total = 0; m_lv = 0;
  endtask

  task automatic model_event(input bit a, input bit v, input bit c, input bit p,
                             input int code, output int e);
    e = 0;
    if (c) model_clear();
    else if (p) begin
      if (m_state == 0) e = 1;
      else if (m_state == 1) m_state = 2;
    end else if (v) begin
      if (m_state == 1 && m_lv) begin
        m_total -= price(m_last);
        m_count--;
        m_lv = 0;
        if (m_count == 0) m_state = 0;
      end else e = 1;
    end else if (a) begin
      if (m_state == 0) begin
        m_state = 1; m_total = price(code); m_count = 1; m_last = code; m_lv = 1;
      end else if (m_state == 1 && m_count < MAXI && m_total + price(code) <= 9999) begin
        m_total += price(code); m_count++; m_last = code; m_lv = 1;
      end else e = 1;
    end
  endtask

  task automatic check_all(input int exp_err, input int got_err);
    int k;
    check_eq("err_pulses", got_err, exp_err);
    check_eq("state", state, m_state);
    check_eq("item_count", item_count, m_count);
    check_eq("last_item", last_item, m_last);
    check_eq("total_cents", total_cents, m_total);
    k = 0;
    while (!bcd_valid && k < 40) begin
      @(negedge clk);
      k++;
    end
    check_eq("bcd_valid", bcd_valid, 1);
    check_eq("total_bcd", total_bcd, to_bcd(m_total));
  endtask

  task automatic fire(input bit a, input bit v, input bit c, input bit p, input int code);
    int e, e0;
    sw[3:0] = code[3:0];
    @(negedge clk);
    e0 = err_seen;
    sw[7:4] = {p, c, v, a};
    repeat (10) @(negedge clk);
    sw[7:4] = 4'b0;
    repeat (10) @(negedge clk);
    model_event(a, v, c, p, code, e);
    check_all(e, err_seen - e0);
  endtask

  task automatic do_reset();
    sw = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    @(negedge clk);
  endtask

  initial begin
    int n, old, e0, kind;
    do_reset();
    check_eq("rst_state", state, 0);
    check_eq("rst_total", total_cents, 0);
    check_eq("rst_bcd", total_bcd, 0);
    check_eq("rst_bcd_valid", bcd_valid, 1);
    check_eq("rst_err", err, 0);

    // Debounce: 3-cycle glitch is rejected, a long press gives one add
    sw[3:0] = 4'd3;
    e0 = err_seen;
    @(negedge clk); sw[4] = 1'b1;
    repeat (3) @(negedge clk); sw[4] = 1'b0;
    repeat (15) @(negedge clk);
    check_eq("glitch_count", item_count, 0);
    check_eq("glitch_err", err_seen - e0, 0);
    fire(1, 0, 0, 0, 3);
    check_eq("debounce_total", total_cents, 200);

    // Sale 0, 15, 2 with BCD latency check on the last add
    do_reset();
    fire(1, 0, 0, 0, 0);
    fire(1, 0, 0, 0, 15);
    sw[3:0] = 4'd2;
    @(negedge clk);
    old = total_cents;
    sw[4] = 1'b1;
    n = 0;
    while (total_cents == old && n < 30) begin
      @(negedge clk);
      n++;
    end
    check_eq("total_changed", int'(total_cents != old), 1);
    @(negedge clk);
    check_eq("bcd_busy", bcd_valid, 0);
    n = 1;
    while (!bcd_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    check_eq("bcd_latency", n, 16);
    sw[4] = 1'b0;
    repeat (10) @(negedge clk);
    model_event(1, 0, 0, 0, 2, e0);
    check_all(0, 0);
    check_eq("sale_bcd", total_bcd, 16'h1000);

    // Void rules
    do_reset();
    fire(1, 0, 0, 0, 0);
    fire(1, 0, 0, 0, 2);
    fire(0, 1, 0, 0, 0);
    check_eq("void_total", total_cents, 50);
    fire(0, 1, 0, 0, 0);
    fire(0, 0, 1, 0, 0);
    fire(1, 0, 0, 0, 7);
    fire(0, 1, 0, 0, 0);
    check_eq("void_idle", state, 0);

    // Limits
    do_reset();
    for (int i = 0; i < 16; i++) fire(1, 0, 0, 0, 0);
    check_eq("max_count", item_count, 15);
    fire(0, 0, 1, 0, 0);
    for (int i = 0; i < 13; i++) fire(1, 0, 0, 0, 15);
    check_eq("max_total", total_cents, 9600);

    // Pay, add after pay, then pay+cancel together from SCAN
    fire(0, 0, 0, 1, 0);
    fire(1, 0, 0, 0, 4);
    fire(0, 0, 0, 1, 0);
    fire(0, 0, 1, 0, 0);
    fire(1, 0, 0, 0, 9);
    fire(0, 0, 1, 1, 0);

    // Asynchronous reset during a conversion
    fire(1, 0, 0, 0, 5);
    sw[3:0] = 4'd5;
    sw[4] = 1'b1;
    n = 0;
    while (bcd_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    check_eq("conv_started", bcd_valid, 0);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_state", state, 0);
    check_eq("arst_count", item_count, 0);
    check_eq("arst_last", last_item, 0);
    check_eq("arst_total", total_cents, 0);
    check_eq("arst_bcd", total_bcd, 0);
    check_eq("arst_bcd_valid", bcd_valid, 1);
    check_eq("arst_err", err, 0);
    do_reset();

    // Random event sequences
    for (int i = 0; i < 100; i++) begin
      kind = $urandom_range(0, 99);
      n = $urandom_range(0, 15);
      if (kind < 55)      fire(1, 0, 0, 0, n);
      else if (kind < 72) fire(0, 1, 0, 0, n);
      else if (kind < 82) fire(0, 0, 0, 1, n);
      else if (kind < 90) fire(0, 0, 1, 0, n);
      else                fire($urandom_range(0, 1), $urandom_range(0, 1), 
                               $urandom_range(0, 1), 1, n);
    end

    $display("test done: total=%0d bad=%0d", total_n, bad_n);
    $finish;
  end
endmodule
